// File: rtl/vc_sched_pkg.sv
// ============================================================================
// Module      : vc_sched_pkg
// Description : Shared constants, state encoding and class-field decode for
//               the VC round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_sched_pkg;

    localparam int NUM_VC      = 4;
    localparam int DFLT_DATA_W = 10;
    localparam int CLASS_W     = 2;
    localparam int CLASS_MSB   = DFLT_DATA_W - 1;
    localparam int CLASS_LSB   = DFLT_DATA_W - CLASS_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    // The class field always occupies the top two bits of a word, whatever
    // the word width; callers zero-extend the word to 32 bits first.
    function automatic logic [1:0] dest_of(input logic [31:0] word, input int width);
        return 2'(word >> (width - CLASS_W));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder; the request at
//               index 'start' has highest priority, then start+1, ... mod 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import vc_sched_pkg::*;
(
    input  logic [NUM_VC-1:0] req,
    input  logic [1:0]        start,
    output logic [1:0]        gnt_idx,
    output logic              gnt_vld
);

    logic [1:0] w_idx;

    // Walk from the farthest position to the nearest so the nearest wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            w_idx = start + 2'(k);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vc_rr_scheduler.sv
// ============================================================================
// Module      : vc_rr_scheduler
// Description : Burst-bounded round-robin scheduler from 4 FWFT source VC
//               FIFOs to 4 destination VC FIFOs, routed by class field.
//               Optional per-source grant counters: VC_SCHED_GRANT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_rr_scheduler
    import vc_sched_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_VC*DATA_W-1:0] data_in,
    input  logic [NUM_VC-1:0]        empty,
    input  logic [NUM_VC-1:0]        almost_full,
    output logic [NUM_VC-1:0]        rd,
    output logic [NUM_VC*DATA_W-1:0] data_out,
    output logic [NUM_VC-1:0]        wr,
    output logic [1:0]               grant_src,
    output logic                     busy
`ifdef VC_SCHED_GRANT_CNT_EN
    ,
    output logic [NUM_VC*16-1:0]     grant_cnt
`endif
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    logic [DATA_W-1:0]        w_head [NUM_VC];
    logic [1:0]               w_dest [NUM_VC];
    logic [NUM_VC-1:0]        w_elig;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [1:0]               r_owner;
    logic [1:0]               w_owner_nxt;
    logic [1:0]               r_rr_ptr;
    logic [1:0]               w_rr_ptr_nxt;
    logic [3:0]               r_burst_cnt;
    logic [3:0]               w_burst_cnt_nxt;

    logic                     w_gnt;
    logic [1:0]               w_gnt_idx;
    logic [1:0]               w_gnt_dest;
    logic [1:0]               w_start;
    logic [1:0]               w_pick_idx;
    logic                     w_pick_vld;

    logic [NUM_VC*DATA_W-1:0] r_data_out;
    logic [NUM_VC-1:0]        r_wr;
    logic [1:0]               r_grant_src;
    logic                     r_busy;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_src
        assign w_head[i] = data_in[i*DATA_W +: DATA_W];
        assign w_dest[i] = dest_of(32'(w_head[i]), DATA_W);
        assign w_elig[i] = !empty[i] && !almost_full[w_dest[i]];
    end

    // When a burst ends the old owner is searched last.
    assign w_start = (r_state == IDLE) ? r_rr_ptr : r_owner + 2'd1;

    rr_pick u_rr_pick (
        .req     (w_elig),
        .start   (w_start),
        .gnt_idx (w_pick_idx),
        .gnt_vld (w_pick_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_gnt           = 1'b0;
        w_gnt_idx       = r_owner;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_gnt           = 1'b1;
                    w_gnt_idx       = w_pick_idx;
                    w_owner_nxt     = w_pick_idx;
                    w_burst_cnt_nxt = 4'd1;
                    w_state_nxt     = BURST;
                end
            end
            BURST: begin
                if (w_elig[r_owner] && (r_burst_cnt < c_MAX_BURST)) begin
                    w_gnt           = 1'b1;
                    w_gnt_idx       = r_owner;
                    w_burst_cnt_nxt = r_burst_cnt + 4'd1;
                end else begin
                    w_rr_ptr_nxt = r_owner + 2'd1;
                    if (w_pick_vld) begin
                        w_gnt           = 1'b1;
                        w_gnt_idx       = w_pick_idx;
                        w_owner_nxt     = w_pick_idx;
                        w_burst_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_gnt_dest = w_dest[w_gnt_idx];

    always_comb begin
        rd = '0;
        if (w_gnt && !reset) begin
            rd = NUM_VC'(1) << w_gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr        <= '0;
            r_data_out  <= '0;
            r_grant_src <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_wr   <= '0;
            r_busy <= (w_state_nxt == BURST);
            if (w_gnt) begin
                r_wr[w_gnt_dest]                         <= 1'b1;
                r_data_out[w_gnt_dest*DATA_W +: DATA_W]  <= w_head[w_gnt_idx];
                r_grant_src                              <= w_gnt_idx;
            end
        end
    end

    assign wr        = r_wr;
    assign data_out  = r_data_out;
    assign grant_src = r_grant_src;
    assign busy      = r_busy;

`ifdef VC_SCHED_GRANT_CNT_EN
    logic [15:0] r_grant_cnt [NUM_VC];

    for (genvar i = 0; i < NUM_VC; i++) begin : g_gcnt
        always_ff @(posedge clk) begin
            if (reset) begin
                r_grant_cnt[i] <= '0;
            end else if (rd[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
`endif

endmodule

`default_nettype wire

// File: doc/vc_rr_scheduler.md
Name: vc_rr_scheduler

Overview:
- Round-robin scheduler between 4 FWFT input VC FIFOs (sources 0..3) and 4 output VC FIFOs (destinations 4..7) in the transaction layer.
- Routes each word by its class field, data[9:8].
- Unlike the fixed-priority router, it grants fairly and holds a source for a bounded burst.
- Honours destination almost_full back-pressure.
- Guarantees exactly one pop per transferred word.

Parameters:
- DATA_W, 10: word width; class field is bits [DATA_W-1:DATA_W-2].
- MAX_BURST, 4: maximum consecutive grants to one source before forced rotation; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  4*DATA_W  head words of source FIFOs; source i = bits [i*DATA_W +: DATA_W].
- empty  in  4  source FIFO empty flags.
- almost_full  in  4  destination FIFO 4..7 almost_full; FIFO threshold must leave at least 1 free slot.
- rd  out  4  combinational pop strobe to source FIFOs; one-hot or zero.
- data_out  out  4*DATA_W  registered word to destination d at bits [d*DATA_W +: DATA_W].
- wr  out  4  registered push strobe to destinations 4..7; one-hot or zero.
- grant_src  out  2  registered index of the last granted source.
- busy  out  1  registered; high while FSM is in BURST.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - wr=0, data_out=0, grant_src=0, busy=0.
  - rr_ptr=0, burst_cnt=0, state=IDLE.
  - rd is forced 0 while reset=1 (combinational gate).
- Eligibility: source i is eligible when empty[i]=0 and almost_full[dest_i]=0, with dest_i = data_in_i[DATA_W-1:DATA_W-2].
- Grant: at most one per cycle.
  - rd[i]=1 in the grant cycle. The FWFT head advances at that edge, so the same word is never re-granted.
- Latency: at the edge ending grant cycle N, data_out[dest] <= data_in_i and wr[dest] <= 1. Push is visible in cycle N+1, so there is 1 cycle of latency.
- No grant in a cycle: wr=0 next cycle. data_out holds its last value, since it is only written on a grant.
- FSM IDLE:
  - Pick the first eligible source searching rr_ptr, rr_ptr+1, ... mod 4.
  - On a pick: owner=i, burst_cnt=1, go to BURST.
  - No eligible source: stay in IDLE.
- FSM BURST:
  - If owner is eligible and burst_cnt<MAX_BURST: grant owner, burst_cnt++.
  - Otherwise: rr_ptr=owner+1 mod 4, then search from owner+1 (owner is searched last).
    - Found: new owner, burst_cnt=1, stay in BURST.
    - None: go to IDLE.
  - The decision is made in the same cycle, with no bubble.
- MAX_BURST=1 gives pure round-robin.
- Back-pressure: a source whose destination is almost_full is skipped, not waited on. There is no head-of-line blocking across sources.
- All sources empty or blocked: rd=0 and no wr, every cycle.
- Simultaneous events: empty deasserting and almost_full rising in the same cycle are evaluated on current-cycle values only.
- Reset mid-burst: the in-flight wr due next cycle is suppressed (wr=0). The popped word is lost; this is acceptable by the system reset policy.
- Width rules:
  - rr_ptr and owner are 2-bit and wrap naturally.
  - burst_cnt is 4-bit and never exceeds MAX_BURST.

Optional Feature:
- Macro: VC_SCHED_GRANT_CNT_EN.
- Defined: adds output grant_cnt, 4*16 bits: per-source saturating grant counters. They increment on each rd[i], hold at 16'hFFFF, and clear on reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package vc_sched_pkg:
  - NUM_VC=4.
  - CLASS_MSB/CLASS_LSB field positions.
  - State encoding IDLE=1'b0, BURST=1'b1.
  - Function dest_of(word).
- Sub-module rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: req[3:0], start[1:0]. Outputs: gnt_idx[1:0], gnt_vld.
  - Instantiated once, with start = rr_ptr in IDLE or owner+1 in BURST.

Test Plan:
- Reset: hold reset=1 for 3 cycles with all sources non-empty -> rd=0, wr=0, data_out=0, busy=0 every cycle.
- Single source: src 2 holds words 10'h1A5, 10'h0C3, 10'h2FF -> rd[2] high 3 consecutive cycles. One cycle later each:
  - wr[1] with data_out slot 1 = 10'h1A5;
  - wr[0] with slot 0 = 10'h0C3;
  - wr[2] with slot 2 = 10'h2FF.
- Fairness, MAX_BURST=4: all 4 sources hold 6 words each for destination 3, almost_full=0 -> grant order src0 x4, src1 x4, src2 x4, src3 x4, src0 x2, src1 x2, ... No gaps, and wr[3] is high 24 consecutive cycles.
- Back-pressure: src0 head class 1, src1 head class 2, almost_full[1]=1 -> src0 is skipped and src1 is granted with wr[2]. Deassert almost_full[1] -> src0 is granted next eligible cycle.
- Burst break: src1 owner with burst_cnt=2 goes empty while src3 is non-empty -> src3 is granted the same cycle (no idle cycle). Then src3 goes empty and all others are empty -> busy=0 next cycle.
- With VC_SCHED_GRANT_CNT_EN: 70000 grants to src0 -> grant_cnt[15:0]=16'hFFFF, and the other counters are 0.
